// File: rtl/ram_rd_stream.sv
// Read sequencer for a pipelined RAM read port: turns {addr, len} commands into a valid/ready stream.
// Optional RAM_RD_STREAM_ERR_EN adds a sticky err_o flag for unexpected returns or buffer overflow.
module ram_rd_stream #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 14,
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = 11,
  parameter int BUF_DEPTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i,
  input  logic                  ram_dout_valid_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o
`ifdef RAM_RD_STREAM_ERR_EN
  ,
  output logic                  err_o
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    cmdReady_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    issueLeft_q;
  logic [LEN_WIDTH-1:0]    outCount_q;
  logic [CNT_W-1:0]        outstanding_q;
  logic [CNT_W-1:0]        bufCount_q;
  logic [PTR_W-1:0]        wrPtr_q, rdPtr_q;
  logic [DATA_WIDTH-1:0]   mem_q [BUF_DEPTH];

  logic                    cmdFire, issue, credit, retAccept, push, pop, lastPop;
  logic                    bufEmpty, bufFull, overflow, isLast;
  logic [SUM_W-1:0]        inFlight;

  // Credit: a read may only issue if its data is guaranteed a buffer slot on return.
  assign inFlight  = SUM_W'(outstanding_q) + SUM_W'(bufCount_q);
  assign credit    = inFlight < SUM_W'(BUF_DEPTH);
  assign cmdFire   = cmd_valid_i && cmdReady_q;
  assign bufEmpty  = (bufCount_q == '0);
  assign bufFull   = (bufCount_q == CNT_W'(BUF_DEPTH));
  assign retAccept = ram_dout_valid_i && (outstanding_q != '0);
  assign pop       = !bufEmpty && m_ready_i;
  assign isLast    = (outCount_q == len_q);
  assign lastPop   = pop && isLast;
  assign overflow  = retAccept && bufFull && !pop;
  assign push      = retAccept && !overflow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmdFire) state_d = ISSUE;
      ISSUE:   if (issue && (issueLeft_q == '0)) state_d = DRAIN;
      DRAIN:   if (lastPop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue  = (state_q == ISSUE) && credit;
    busy_o = (state_q != IDLE);
  end

  assign cmd_ready_o = cmdReady_q;
  assign ram_en_o    = issue;
  assign ram_addr_o  = addr_q;
  assign m_valid_o   = !bufEmpty;
  assign m_data_o    = bufEmpty ? '0 : mem_q[rdPtr_q];
  assign m_last_o    = !bufEmpty && isLast;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmdReady_q    <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      issueLeft_q   <= '0;
      outCount_q    <= '0;
      outstanding_q <= '0;
      bufCount_q    <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
    end else begin
      cmdReady_q <= (state_d == IDLE);
      if (cmdFire) begin
        addr_q      <= cmd_addr_i;
        len_q       <= cmd_len_i;
        issueLeft_q <= cmd_len_i;
        outCount_q  <= '0;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + 1'b1;
          issueLeft_q <= issueLeft_q - 1'b1;
        end
        if (lastPop)  outCount_q <= '0;
        else if (pop) outCount_q <= outCount_q + 1'b1;
      end
      if (issue && !retAccept)      outstanding_q <= outstanding_q + 1'b1;
      else if (!issue && retAccept) outstanding_q <= outstanding_q - 1'b1;
      if (push && !pop)      bufCount_q <= bufCount_q + 1'b1;
      else if (pop && !push) bufCount_q <= bufCount_q - 1'b1;
      if (push) wrPtr_q <= (wrPtr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= (rdPtr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wrPtr_q] <= ram_dout_i;
  end

`ifdef RAM_RD_STREAM_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else if ((ram_dout_valid_i && (outstanding_q == '0) && busy_o) || overflow) err_q <= 1'b1;
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_ram_rd_stream.sv
// Randomized scoreboard bench for ram_rd_stream with a behavioural RAM and an expected-word queue.
module tb_ram_rd_stream;
  localparam int DW = 36;
  localparam int AW = 6;
  localparam int LW = 16;
  localparam int L  = 11;
  localparam int D  = 16;
  localparam int RAM_WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic ram_dout_valid;
  logic m_valid, m_ready, m_last, busy;
  logic [DW-1:0] m_data;
`ifdef RAM_RD_STREAM_ERR_EN
  logic err;
`endif

  always #5 clk = ~clk;

  ram_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                  .RD_LATENCY(L), .BUF_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr),
    .ram_dout_i(ram_dout), .ram_dout_valid_i(ram_dout_valid),
    .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_last_o(m_last),
`ifdef RAM_RD_STREAM_ERR_EN
    .err_o(err),
`endif
    .busy_o(busy)
  );

  // Behavioural RAM: contents fixed at start, read pipe of L stages that ignores reset.
  logic [DW-1:0] ramMem [RAM_WORDS];
  logic          pipeValid [L];
  logic [DW-1:0] pipeData  [L];
  logic          injectPulse = 1'b0;

  always @(posedge clk) begin
    pipeValid[0] <= ram_en;
    pipeData[0]  <= ramMem[ram_addr];
    for (int i = L - 1; i > 0; i--) begin
      pipeValid[i] <= pipeValid[i-1];
      pipeData[i]  <= pipeData[i-1];
    end
  end

  assign ram_dout_valid = pipeValid[L-1] | injectPulse;
  assign ram_dout       = injectPulse ? 36'hBADBADBAD : pipeData[L-1];

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int readyMode = 0;
  int readyPhase = 0;
  int issuedCnt = 0;
  int poppedCnt = 0;
  int maxInflight = 0;

  logic [DW-1:0] expData [$];
  bit            expLast [$];
  logic [AW-1:0] expAddr [$];

  always @(posedge clk) cycle <= cycle + 1;

  // Sink readiness changes just after each active edge.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: m_ready = 1'b1;
      1: begin m_ready = (readyPhase == 0); readyPhase = (readyPhase + 1) % 4; end
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: pops the scoreboard on every issued read and every accepted beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_en) begin
        issuedCnt++;
        if (expAddr.size() == 0) begin
          errors++; checks++;
          $display("[TB] FAIL unexpectedIssue: got addr %0h expected none", ram_addr);
        end else checkOutput("ramAddr", 64'(ram_addr), 64'(expAddr.pop_front()));
      end
      if (m_valid && m_ready) begin
        poppedCnt++;
        if (expData.size() == 0) begin
          errors++; checks++;
          $display("[TB] FAIL unexpectedBeat: got data %0h expected none", m_data);
        end else begin
          checkOutput("beatData", 64'(m_data), 64'(expData.pop_front()));
          checkOutput("beatLast", 64'(m_last), 64'(expLast.pop_front()));
        end
      end
      if (issuedCnt - poppedCnt > maxInflight) maxInflight = issuedCnt - poppedCnt;
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] addr, input int len);
    int n = 0;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin
      errors++; checks++;
      $display("[TB] FAIL cmdReadyTimeout: got 0 expected 1");
      return;
    end
    for (int i = 0; i <= len; i++) begin
      logic [AW-1:0] a;
      a = AW'((int'(addr) + i) % RAM_WORDS);
      expAddr.push_back(a);
      expData.push_back(ramMem[a]);
      expLast.push_back(i == len);
    end
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = LW'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy || expData.size() != 0) && n < budget) begin @(posedge clk); #1; n++; end
    checkOutput("cmdDone", 64'(busy == 1'b0 && expData.size() == 0), 64'd1);
    checkOutput("cmdReadyIdle", 64'(cmd_ready), 64'd1);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rstCmdReady", 64'(cmd_ready), 64'd0);
    checkOutput("rstRamEn",    64'(ram_en),    64'd0);
    checkOutput("rstRamAddr",  64'(ram_addr),  64'd0);
    checkOutput("rstMValid",   64'(m_valid),   64'd0);
    checkOutput("rstMData",    64'(m_data),    64'd0);
    checkOutput("rstMLast",    64'(m_last),    64'd0);
    checkOutput("rstBusy",     64'(busy),      64'd0);
`ifdef RAM_RD_STREAM_ERR_EN
    checkOutput("rstErr",      64'(err),       64'd0);
`endif
  endtask

  initial begin
    int n, enCycle, gaps, sawValid;
    for (int i = 0; i < RAM_WORDS; i++) ramMem[i] = DW'({$urandom(), $urandom()});
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    #1;
    checkResetOutputs();
    repeat (20) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("readyHeldLow", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    checkOutput("readyAfterReset", 64'(cmd_ready), 64'd1);

    // Single word: first beat arrives RD_LATENCY+1 cycles after the read.
    readyMode = 0;
    applyStimulus(6'h10, 0);
    n = 0;
    while (!ram_en && n < 20) begin @(posedge clk); #1; n++; end
    enCycle = cycle;
    while (!m_valid && n < 60) begin @(posedge clk); #1; n++; end
    checkOutput("firstLatency", 64'(cycle - enCycle), 64'(L + 1));
    checkOutput("singleLast", 64'(m_last), 64'd1);
    waitIdle(100);

    // Full burst must stream without bubbles.
    applyStimulus(6'h00, 63);
    n = 0;
    while (!m_valid && n < 60) begin @(posedge clk); #1; n++; end
    gaps = 0;
    for (int i = 0; i < 64; i++) begin
      if (!m_valid) gaps++;
      @(posedge clk); #1;
    end
    checkOutput("burstGaps", 64'(gaps), 64'd0);
    waitIdle(100);

    readyMode = 1;
    applyStimulus(AW'($urandom_range(0, RAM_WORDS - 1)), 31);
    waitIdle(400);

    readyMode = 0;
    applyStimulus(6'd62, 3);
    waitIdle(100);
    applyStimulus(6'd50, 100);
    waitIdle(300);

    for (int k = 0; k < 6; k++) begin
      readyMode = $urandom_range(0, 2);
      applyStimulus(AW'($urandom_range(0, RAM_WORDS - 1)), $urandom_range(0, 40));
      waitIdle(600);
    end

    // Spurious return while draining must be ignored (and flagged when err_o exists).
    readyMode = 3;
    applyStimulus(6'd5, 0);
    n = 0;
    while (!m_valid && n < 60) begin @(posedge clk); #1; n++; end
    injectPulse = 1'b1;
    @(posedge clk); #1;
    injectPulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifdef RAM_RD_STREAM_ERR_EN
    checkOutput("errSet", 64'(err), 64'd1);
`endif
    readyMode = 0;
    waitIdle(100);
    repeat (5) @(posedge clk);
    #1;
`ifdef RAM_RD_STREAM_ERR_EN
    checkOutput("errSticky", 64'(err), 64'd1);
`endif

    // Reset mid-burst, then stale RAM returns must not surface.
    applyStimulus(6'd20, 63);
    n = 0;
    while (issuedCnt - poppedCnt < 5 && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    #1;
    checkResetOutputs();
    expAddr.delete(); expData.delete(); expLast.delete();
    issuedCnt = 0; poppedCnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sawValid = 0;
    for (int i = 0; i < L + 6; i++) begin
      @(posedge clk); #1;
      if (m_valid) sawValid++;
    end
    checkOutput("staleDropped", 64'(sawValid), 64'd0);
    applyStimulus(6'd7, 0);
    waitIdle(100);

    checkOutput("creditBound", 64'(maxInflight <= D), 64'd1);
    checkOutput("addrQueueEmpty", 64'(expAddr.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
